// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - state encodings, widths and Moore output decode shared by the fetch sequencer
package fetch_seq_pkg;

    localparam int STATE_WIDTH   = 3;
    localparam int TIMEOUT_WIDTH = 8;

    localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_ADDR  = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_REQ   = 3'd2;
    localparam logic [STATE_WIDTH-1:0] ST_LOAD  = 3'd3;
    localparam logic [STATE_WIDTH-1:0] ST_START = 3'd4;
    localparam logic [STATE_WIDTH-1:0] ST_WAIT  = 3'd5;
    localparam logic [STATE_WIDTH-1:0] ST_FAULT = 3'd6;

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE  = ST_IDLE,
        S_ADDR  = ST_ADDR,
        S_REQ   = ST_REQ,
        S_LOAD  = ST_LOAD,
        S_START = ST_START,
        S_WAIT  = ST_WAIT,
        S_FAULT = ST_FAULT
    } state_e;

    typedef struct packed {
        logic pc_enable;
        logic pc_count;
        logic mar_load;
        logic mem_req;
        logic mem_enable;
        logic ir_load;
        logic exec_start;
        logic busy;
        logic fault;
    } strobes_t;

    // Each state owns at most one bus driver; PC and memory never share a state.
    function automatic strobes_t decode_state(state_e s);
        strobes_t o;
        o      = '0;
        o.busy = (s != S_IDLE);
        case (s)
            S_ADDR: begin
                o.pc_enable = 1'b1;
                o.mar_load  = 1'b1;
            end
            S_REQ:   o.mem_req = 1'b1;
            S_LOAD: begin
                o.mem_enable = 1'b1;
                o.ir_load    = 1'b1;
                o.pc_count   = 1'b1;
            end
            S_START: o.exec_start = 1'b1;
            S_FAULT: o.fault      = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - handshake inputs and register strobes between the sequencer and the fetch datapath
interface fetch_sequencer_if;

    logic RUN;
    logic HALT_REQ;
    logic MEM_ACK;
    logic EXEC_DONE;
    logic PC_ENABLE;
    logic PC_COUNT;
    logic MAR_LOAD;
    logic MEM_REQ;
    logic MEM_ENABLE;
    logic IR_LOAD;
    logic EXEC_START;
    logic BUSY;
    logic FAULT;
    logic [fetch_seq_pkg::STATE_WIDTH-1:0] STATE;

    modport master (
        input  RUN, HALT_REQ, MEM_ACK, EXEC_DONE,
        output PC_ENABLE, PC_COUNT, MAR_LOAD, MEM_REQ, MEM_ENABLE,
               IR_LOAD, EXEC_START, BUSY, FAULT, STATE
    );

    modport slave (
        output RUN, HALT_REQ, MEM_ACK, EXEC_DONE,
        input  PC_ENABLE, PC_COUNT, MAR_LOAD, MEM_REQ, MEM_ENABLE,
               IR_LOAD, EXEC_START, BUSY, FAULT, STATE
    );

endinterface

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - saturating count of unacknowledged REQ cycles with an expiry flag
module fetch_timeout_counter
    import fetch_seq_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_WIDTH:0] LIMIT_W = (TIMEOUT_WIDTH + 1)'(LIMIT);

    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the miss that brings the count to LIMIT on this edge, so an ack in that cycle still wins.
    assign expired_o = en_i && (({1'b0, cnt_q} + 1'b1) >= LIMIT_W);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch control FSM; FETCH_TIMEOUT_EN adds the REQ timeout and FAULT state
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int BUS_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               CLOCK,
    input  logic               RESET,
    fetch_sequencer_if.master  bus
);

    if ((BUS_WIDTH < 1) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_param_check
        $error("fetch_sequencer: BUS_WIDTH must be positive and TIMEOUT_CYCLES within 1..255");
    end

    state_e   state_q;
    state_e   state_d;
    strobes_t out_q;
    logic     timeout_hit;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (CLOCK),
        .rst_ni    (RESET),
        .clear_i   (state_q == S_ADDR),
        .en_i      ((state_q == S_REQ) && !bus.MEM_ACK),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.RUN) state_d = S_ADDR;
            S_ADDR:  state_d = S_REQ;
            S_REQ: begin
                if (bus.MEM_ACK) begin
                    state_d = S_LOAD;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                // RUN is only consulted here, so a dropped RUN lets the current instruction finish.
                if (bus.EXEC_DONE) begin
                    state_d = (bus.HALT_REQ || !bus.RUN) ? S_IDLE : S_ADDR;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they sit in flops aligned with state_q.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= decode_state(state_d);
        end
    end

    assign bus.PC_ENABLE  = out_q.pc_enable;
    assign bus.PC_COUNT   = out_q.pc_count;
    assign bus.MAR_LOAD   = out_q.mar_load;
    assign bus.MEM_REQ    = out_q.mem_req;
    assign bus.MEM_ENABLE = out_q.mem_enable;
    assign bus.IR_LOAD    = out_q.ir_load;
    assign bus.EXEC_START = out_q.exec_start;
    assign bus.BUSY       = out_q.busy;
    assign bus.FAULT      = out_q.fault;
    assign bus.STATE      = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector table, corner sequences and randomized model check of fetch_sequencer
module tb_fetch_sequencer;

    localparam int TO = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic CLOCK;
    logic RESET;
    int   checks;
    int   errors;
    int   m_state;
    int   m_miss;

    fetch_sequencer_if bus_if ();

    fetch_sequencer #(
        .BUS_WIDTH      (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus_if.master)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic run;
        logic halt;
        logic ack;
        logic done;
        int   exp_state;
    } vec_t;

    vec_t tbl[$];

    // {PC_ENABLE,PC_COUNT,MAR_LOAD,MEM_REQ,MEM_ENABLE,IR_LOAD,EXEC_START,BUSY,FAULT,STATE}
    function automatic logic [11:0] exp_vec(int st);
        logic [8:0] s;
        case (st)
            1:       s = 9'b101000010;
            2:       s = 9'b000100010;
            3:       s = 9'b010011010;
            4:       s = 9'b000000110;
            5:       s = 9'b000000010;
            6:       s = 9'b000000011;
            default: s = 9'b000000000;
        endcase
        return {s, 3'(st)};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus_if.PC_ENABLE, bus_if.PC_COUNT, bus_if.MAR_LOAD, bus_if.MEM_REQ,
                bus_if.MEM_ENABLE, bus_if.IR_LOAD, bus_if.EXEC_START, bus_if.BUSY,
                bus_if.FAULT, bus_if.STATE};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act    = dut_vec();
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Fetch protocol as stated: one address cycle, request until acked, load, start, wait for done.
    function automatic void model_step(logic run, logic halt, logic ack, logic done);
        case (m_state)
            0: if (run) m_state = 1;
            1: begin
                m_state = 2;
                m_miss  = 0;
            end
            2: begin
                if (ack) begin
                    m_state = 3;
                end else begin
                    m_miss = m_miss + 1;
                    if (TO_EN && (m_miss >= TO)) m_state = 6;
                end
            end
            3: m_state = 4;
            4: m_state = 5;
            5: if (done) m_state = (halt || !run) ? 0 : 1;
            default: ;
        endcase
    endfunction

    task automatic step(input logic run, input logic halt, input logic ack, input logic done);
        bus_if.RUN       = run;
        bus_if.HALT_REQ  = halt;
        bus_if.MEM_ACK   = ack;
        bus_if.EXEC_DONE = done;
        @(posedge CLOCK);
        model_step(run, halt, ack, done);
        #1;
    endtask

    // Called just after an edge; asserts and releases reset well clear of the next edge.
    task automatic pulse_reset(input string name);
        #2 RESET = 1'b0;
        #1 check(name, 12'h000);
        #2 RESET = 1'b1;
        m_state = 0;
        m_miss  = 0;
    endtask

    function automatic void add(logic r, logic h, logic a, logic d, int s);
        vec_t v;
        v.run = r; v.halt = h; v.ack = a; v.done = d; v.exp_state = s;
        tbl.push_back(v);
    endfunction

    initial begin
        int pc_pulses;
        int mar_pulses;
        logic r, h, a, d;

        checks  = 0;
        errors  = 0;
        m_state = 0;
        m_miss  = 0;
        RESET   = 1'b0;
        bus_if.RUN       = 1'b0;
        bus_if.HALT_REQ  = 1'b0;
        bus_if.MEM_ACK   = 1'b0;
        bus_if.EXEC_DONE = 1'b0;

        add(0,0,0,0, 0);
        add(1,0,1,1, 1); add(1,0,1,1, 2); add(1,0,1,1, 3); add(1,0,1,1, 4);
        add(1,0,1,1, 5); add(1,0,1,1, 1); add(1,0,1,1, 2);
        add(1,0,0,0, 2); add(1,0,0,0, 2); add(1,0,0,0, 2); add(1,0,1,0, 3);
        add(1,0,1,0, 4); add(1,0,1,1, 5); add(1,0,1,0, 5); add(1,1,1,1, 0);
        add(0,0,0,0, 0); add(0,0,1,1, 0);
        add(1,0,0,0, 1); add(0,0,1,0, 2); add(0,0,0,0, 2); add(0,0,1,0, 3);
        add(0,0,0,0, 4); add(0,0,0,1, 5); add(0,0,0,1, 0);

        #12 check("reset_state", 12'h000);
        @(posedge CLOCK);
        #1 RESET = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].run, tbl[i].halt, tbl[i].ack, tbl[i].done);
            check($sformatf("vec%0d", i), exp_vec(tbl[i].exp_state));
        end

        pc_pulses  = 0;
        mar_pulses = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 1, 1);
            check("period", exp_vec(m_state));
            pc_pulses  = pc_pulses + int'(bus_if.PC_COUNT);
            mar_pulses = mar_pulses + int'(bus_if.MAR_LOAD);
        end
        checks = checks + 1;
        if (pc_pulses != 3) begin
            errors = errors + 1;
            $display("FAIL pc_count_pulses: got %0d want 3", pc_pulses);
        end
        checks = checks + 1;
        if (mar_pulses != 3) begin
            errors = errors + 1;
            $display("FAIL mar_load_pulses: got %0d want 3", mar_pulses);
        end
        step(1, 1, 1, 1);
        check("halt_after_period", exp_vec(0));

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("enter_req", exp_vec(2));
        pulse_reset("reset_mid_req");
        step(1, 0, 0, 0);
        check("restart_addr", exp_vec(1));

        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            check("req_miss", exp_vec(2));
        end
        step(1, 0, 0, 0);
        check("timeout_4", exp_vec(TO_EN ? 6 : 2));
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 1);
            check("after_timeout", exp_vec(m_state));
        end
        pulse_reset("reset_from_fault");

        for (int i = 0; i < 800; i++) begin
            if (($urandom_range(0, 99) == 0) || ((m_state == 6) && ($urandom_range(0, 3) == 0))) begin
                pulse_reset("rand_reset");
            end else begin
                r = ($urandom_range(0, 7) != 0);
                h = ($urandom_range(0, 5) == 0);
                a = ($urandom_range(0, 2) != 0);
                d = ($urandom_range(0, 2) == 0);
                step(r, h, a, d);
                check("random", exp_vec(m_state));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
